div_iter: RTL

Iterative radix-2 restoring divider for the execute stage. It feeds the execute ALU's HI/LO path: the ALU holds `start_i` for DIV/DIVU, stalls until `ready_o`, then writes `result_o` into HI/LO. Each divide takes 32 iterations, with an optional fast path for a zero divisor. The block is flushable from the pipeline so that exceptions and branch flushes abandon an in-flight divide.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_step.sv | 25 ++
 rtl/div_iter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants, types and helpers for the iterative restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  // Per-divide facts captured at start and needed again at the sign fix-up.
  typedef struct packed {
    logic is_signed;
    logic neg_dividend;
    logic neg_divisor;
    logic div_zero;
  } div_ctrl_t;

  // Magnitude of an operand; 0x80000000 maps onto itself as an unsigned value.
  function automatic logic [DIV_WIDTH-1:0] abs_mag(input logic [DIV_WIDTH-1:0] v,
                                                  input logic                 is_signed);
    return (is_signed && v[DIV_WIDTH-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, subtract the divisor
// and keep the difference when it is non-negative.
import div_pkg::*;

module div_step (
  input  logic [DIV_WIDTH:0]   rem_i,
  input  logic [DIV_WIDTH-1:0] quo_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic [DIV_WIDTH:0]   rem_o,
  output logic [DIV_WIDTH-1:0] quo_o
);
  logic [DIV_WIDTH+1:0] shifted;
  logic [DIV_WIDTH+1:0] trial;
  logic                 take;

  // NOTE: combinational logic uses blocking assignments, and every output is
  // assigned on every path so no latch is inferred.
  always_comb begin
    shifted = {rem_i, quo_i[DIV_WIDTH-1]};
    trial   = shifted - {2'b00, divisor_i};
    take    = (shifted >= {2'b00, divisor_i});
    rem_o   = (DIV_WIDTH+1)'(take ? trial : shifted);
    quo_o   = {quo_i[DIV_WIDTH-2:0], take};
  end
endmodule

// File: rtl/div_iter.sv
// Iterative 32-step restoring divider with sign fix-up and pipeline abort.
// Define DIV_ZERO_FAST_EN to finish a zero-divisor divide in one cycle.
import div_pkg::*;

module div_iter #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);
  div_state_t         state_q, state_d;
  div_ctrl_t          ctrl_q, ctrl_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   fix_rem, fix_quo;
  logic               abort, capture, last_step, zero_fast;

  assign abort     = flush | annul_i;
  assign capture   = (state_q == IDLE) && start_i && !abort;
  assign last_step = (state_q == BUSY) && (cnt_q == 6'(DIV_ITERS - 1));

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = (opdata2_i == '0);
`else
  assign zero_fast = 1'b0;
`endif

  div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = zero_fast ? DONE : BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort beats everything except reset, including a pending DONE.
    if (abort) state_d = IDLE;
  end

  // Sign fix-up applied to the values leaving the final iteration.
  always_comb begin
    fix_quo = (ctrl_q.is_signed && (ctrl_q.neg_dividend ^ ctrl_q.neg_divisor))
            ? -step_quo : step_quo;
    fix_rem = (ctrl_q.is_signed && ctrl_q.neg_dividend)
            ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
  end

  always_comb begin
    ready_d  = (state_d == DONE);
    result_d = result_q;
    if (state_d == DONE) begin
      if (state_q == IDLE)      result_d = {opdata1_i, DIV_ZERO_QUOT};
      else if (ctrl_q.div_zero) result_d = {dividend_q, DIV_ZERO_QUOT};
      else                      result_d = {fix_rem, fix_quo};
    end
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    if (capture) begin
      ctrl_d.is_signed    = signed_div_i;
      ctrl_d.neg_dividend = signed_div_i & opdata1_i[WIDTH-1];
      ctrl_d.neg_divisor  = signed_div_i & opdata2_i[WIDTH-1];
      ctrl_d.div_zero     = (opdata2_i == '0);
      cnt_d      = '0;
      rem_d      = '0;
      quo_d      = abs_mag(opdata1_i, signed_div_i);
      divisor_d  = abs_mag(opdata2_i, signed_div_i);
      dividend_d = opdata1_i;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q + 6'd1;
      rem_d = step_rem;
      quo_d = step_quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  // NOTE: datapath registers carry no reset; each divide loads them at
  // capture before any of them is consumed.
  always_ff @(posedge clk) begin
    ctrl_q     <= ctrl_d;
    rem_q      <= rem_d;
    quo_q      <= quo_d;
    divisor_q  <= divisor_d;
    dividend_q <= dividend_d;
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;
endmodule
